// File: rtl/recovery_sequencer.sv
// ---------------------------------------------------------------------------
// recovery_sequencer
//
// Rolls the core back to its shadow register state after the lockstep
// comparator reports a mismatch. The sequence is: block fetch, wait for the
// pipeline to drain, copy shadow GPRs x1..xN into the core register file one
// register per cycle, then release the core. A further error during the copy
// restarts the copy from x1. Once the retry budget is spent, a further error
// raises a sticky fatal flag that only reset clears.
//
// Optional feature macro: RECOVERY_VERIFY_EN
//   When defined, a read-back VERIFY pass follows COPY. It compares the core
//   RF against the shadow file, and any mismatch counts as a retry. This adds
//   the rf_rdata_i port.
//
// Parameters
//   ADDR_WIDTH  register address width (registers 1..2^ADDR_WIDTH-1 copied)
//   DATA_WIDTH  register data width
//   MAX_RETRY   restarts allowed per recovery episode before fatal
//
// Ports
//   clk_i          clock
//   rst_n          synchronous active-low reset
//   error_i        comparator mismatch (level)
//   halt_ack_i     core drained and halted (level)
//   sgpr_raddr_o   shadow GPR read address
//   sgpr_rdata_i   shadow GPR read data (combinational from sgpr_raddr_o)
//   rf_rdata_i     core RF read data (RECOVERY_VERIFY_EN only)
//   rf_we_o        core RF write enable
//   rf_waddr_o     core RF write address
//   rf_wdata_o     core RF write data (pass-through of sgpr_rdata_i)
//   fetch_block_o  stall instruction fetch
//   done_o         one-cycle pulse when recovery completes
//   fatal_o        sticky, retry budget exhausted
//   retry_cnt_o    restarts taken in the current episode
// ---------------------------------------------------------------------------
module recovery_sequencer #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_RETRY  = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_n,
  input  logic                           error_i,
  input  logic                           halt_ack_i,
  output logic [ADDR_WIDTH-1:0]          sgpr_raddr_o,
  input  logic [DATA_WIDTH-1:0]          sgpr_rdata_i,
`ifdef RECOVERY_VERIFY_EN
  input  logic [DATA_WIDTH-1:0]          rf_rdata_i,
`endif
  output logic                           rf_we_o,
  output logic [ADDR_WIDTH-1:0]          rf_waddr_o,
  output logic [DATA_WIDTH-1:0]          rf_wdata_o,
  output logic                           fetch_block_o,
  output logic                           done_o,
  output logic                           fatal_o,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt_o
);

  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = {ADDR_WIDTH{1'b1}};
  localparam logic [RW-1:0]         RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_COPY,
    S_VERIFY,
    S_DONE,
    S_FATAL
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [RW-1:0]         retry_cnt;
  logic                  fetch_block;
  logic                  rf_we;
  logic                  done;
  logic                  fatal;
  logic                  retry_req;

  // A retry is requested by a comparator error. When verification is built
  // in, a read-back mismatch during the VERIFY walk also requests a retry.
  // Only COPY and VERIFY act on it.
`ifdef RECOVERY_VERIFY_EN
  logic verify_miss;
  assign verify_miss = (rf_rdata_i != sgpr_rdata_i);
  assign retry_req   = error_i | ((state == S_VERIFY) & verify_miss);
`else
  assign retry_req   = error_i;
`endif

  // Single sequencing process. Outputs are registered alongside the state so
  // that each one follows the state it belongs to without decode glitches.
  // On a retry, the write in the cycle that sees the error still happens;
  // only the next cycle restarts at x1. The error check comes before the
  // terminal check, so an error on the last register still restarts the copy.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= FIRST_IDX;
      retry_cnt   <= '0;
      fetch_block <= 1'b0;
      rf_we       <= 1'b0;
      done        <= 1'b0;
      fatal       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (error_i) begin
            state       <= S_HALT;
            fetch_block <= 1'b1;
          end
        end

        S_HALT: begin
          if (halt_ack_i) begin
            state <= S_COPY;
            idx   <= FIRST_IDX;
            rf_we <= 1'b1;
          end
        end

        S_COPY, S_VERIFY: begin
          if (retry_req) begin
            idx <= FIRST_IDX;
            if (retry_cnt == RETRY_MAX) begin
              state <= S_FATAL;
              fatal <= 1'b1;
              rf_we <= 1'b0;
            end else begin
              state     <= S_COPY;
              retry_cnt <= retry_cnt + RW'(1);
              rf_we     <= 1'b1;
            end
          end else if (idx == LAST_IDX) begin
            idx   <= FIRST_IDX;
            rf_we <= 1'b0;
`ifdef RECOVERY_VERIFY_EN
            if (state == S_COPY) begin
              state <= S_VERIFY;
            end else begin
              state     <= S_DONE;
              done      <= 1'b1;
              retry_cnt <= '0;
            end
`else
            state     <= S_DONE;
            done      <= 1'b1;
            retry_cnt <= '0;
`endif
          end else begin
            idx <= idx + ADDR_WIDTH'(1);
          end
        end

        S_DONE: begin
          state       <= S_IDLE;
          fetch_block <= 1'b0;
        end

        S_FATAL: begin
          // Sticky until reset; error_i is deliberately ignored here.
          state <= S_FATAL;
        end

        default: begin
          state       <= S_IDLE;
          idx         <= FIRST_IDX;
          retry_cnt   <= '0;
          fetch_block <= 1'b0;
          rf_we       <= 1'b0;
          fatal       <= 1'b0;
        end
      endcase
    end
  end

  assign sgpr_raddr_o  = idx;
  assign rf_waddr_o    = idx;
  assign rf_wdata_o    = sgpr_rdata_i;
  assign rf_we_o       = rf_we;
  assign fetch_block_o = fetch_block;
  assign done_o        = done;
  assign fatal_o       = fatal;
  assign retry_cnt_o   = retry_cnt;

endmodule

// File: tb/tb_recovery_sequencer.sv
// ---------------------------------------------------------------------------
// tb_recovery_sequencer
//
// Episode-based bench for recovery_sequencer in the default build, with
// verification disabled. For every recovery episode, the expected per-cycle
// waveform is planned up front from the sequencing rules:
//   - drain wait until the acknowledge is seen
//   - back-to-back write passes 1..k, truncated at each injected error
//   - a final full pass and a done pulse, or the fatal hold after the
//     retry budget is exceeded, or an early reset
// The episode is then played cycle by cycle and the DUT is compared against
// the plan.
// ---------------------------------------------------------------------------
module tb_recovery_sequencer;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int MAXR = 3;
  localparam int RW   = $clog2(MAXR + 1);
  localparam int NREG = (1 << AW) - 1;
  localparam int MAXL = 512;

  logic          clk_i = 1'b0;
  logic          rst_n;
  logic          error_i;
  logic          halt_ack_i;
  logic [AW-1:0] sgpr_raddr_o;
  logic [DW-1:0] sgpr_rdata_i;
  logic          rf_we_o;
  logic [AW-1:0] rf_waddr_o;
  logic [DW-1:0] rf_wdata_o;
  logic          fetch_block_o;
  logic          done_o;
  logic          fatal_o;
  logic [RW-1:0] retry_cnt_o;

  int total = 0;
  int bad   = 0;

  // Shadow GPR file seen by the DUT through its read port.
  logic [DW-1:0] sgpr_mem [0:NREG];
  assign sgpr_rdata_i = sgpr_mem[sgpr_raddr_o];

  // Planned stimulus and expected waveform for one episode.
  bit err_drv [MAXL];
  bit ack_drv [MAXL];
  bit rst_drv [MAXL];
  bit e_fetch [MAXL];
  bit e_we    [MAXL];
  bit e_done  [MAXL];
  bit e_fatal [MAXL];
  bit c_addr  [MAXL];
  bit c_retry [MAXL];
  int e_addr  [MAXL];
  int e_retry [MAXL];
  int ep_len;
  int ep_num = 0;
  int err_pos [4];

  always #5 clk_i = ~clk_i;

  recovery_sequencer #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_RETRY (MAXR)
  ) dut (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .error_i      (error_i),
    .halt_ack_i   (halt_ack_i),
    .sgpr_raddr_o (sgpr_raddr_o),
    .sgpr_rdata_i (sgpr_rdata_i),
    .rf_we_o      (rf_we_o),
    .rf_waddr_o   (rf_waddr_o),
    .rf_wdata_o   (rf_wdata_o),
    .fetch_block_o(fetch_block_o),
    .done_o       (done_o),
    .fatal_o      (fatal_o),
    .retry_cnt_o  (retry_cnt_o)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Plan an episode.
  //   h      : first cycle halt_ack_i is high (0 means already high)
  //   nerr   : number of errors injected during copy (err_pos[] holds the
  //            register index whose write cycle carries each error)
  //   rst_at : if nonzero, pulse reset during the write of that index
  task automatic applyStimulus(input int h, input int nerr, input int rst_at);
    int a, c, p, len;
    for (int i = 0; i < MAXL; i++) begin
      err_drv[i] = 0;
      ack_drv[i] = (i >= h);
      rst_drv[i] = 0;
      e_fetch[i] = 1;
      e_we[i]    = 0;
      e_done[i]  = 0;
      e_fatal[i] = 0;
      c_addr[i]  = 0;
      c_retry[i] = 1;
      e_addr[i]  = 1;
      e_retry[i] = 0;
    end
    // Cycle 0: idle, the comparator fires.
    err_drv[0] = 1;
    e_fetch[0] = 0;
    c_addr[0]  = 1;
    // Drain wait. Errors seen here are already covered by this recovery.
    a = (h < 1) ? 1 : h;
    for (int i = 1; i <= a; i++) err_drv[i] = 1'($urandom_range(0, 1));
    c = a + 1;
    p = 0;
    forever begin
      len = (p < nerr) ? err_pos[p] : NREG;
      for (int ad = 1; ad <= len; ad++) begin
        e_we[c]    = 1;
        c_addr[c]  = 1;
        e_addr[c]  = ad;
        e_retry[c] = p;
        if (rst_at == ad) begin
          rst_drv[c] = 1;
          c++;
          e_fetch[c] = 0;
          c_addr[c]  = 1;
          ep_len     = c + 1;
          return;
        end
        c++;
      end
      if (p < nerr) begin
        err_drv[c-1] = 1;
        if (p == MAXR) break;
        p++;
      end else begin
        break;
      end
    end
    if (nerr > MAXR) begin
      // Fatal hold: fetch stays blocked, no writes, errors ignored.
      for (int k = 0; k < 100; k++) begin
        e_fatal[c] = 1;
        e_retry[c] = MAXR;
        err_drv[c] = 1'($urandom_range(0, 1));
        c++;
      end
      rst_drv[c-1] = 1;
    end else begin
      e_done[c]  = 1;
      c_retry[c] = 0;
      err_drv[c] = 1'($urandom_range(0, 1));
      c++;
    end
    // Back in idle with everything released.
    e_fetch[c] = 0;
    c_addr[c]  = 1;
    ep_len     = c + 1;
  endtask

  task automatic runEpisode();
    string pre;
    ep_num++;
    for (int c = 0; c < ep_len; c++) begin
      @(posedge clk_i);
      #1;
      error_i    = err_drv[c];
      halt_ack_i = ack_drv[c];
      rst_n      = !rst_drv[c];
      @(negedge clk_i);
      pre = $sformatf("ep%0d c%0d", ep_num, c);
      checkOutput({pre, " fetch_block"}, 64'(fetch_block_o), 64'(e_fetch[c]));
      checkOutput({pre, " rf_we"}, 64'(rf_we_o), 64'(e_we[c]));
      checkOutput({pre, " done"}, 64'(done_o), 64'(e_done[c]));
      checkOutput({pre, " fatal"}, 64'(fatal_o), 64'(e_fatal[c]));
      if (c_addr[c]) begin
        checkOutput({pre, " rf_waddr"}, 64'(rf_waddr_o), 64'(e_addr[c]));
        checkOutput({pre, " sgpr_raddr"}, 64'(sgpr_raddr_o), 64'(e_addr[c]));
      end
      if (e_we[c]) checkOutput({pre, " rf_wdata"}, 64'(rf_wdata_o), 64'(sgpr_mem[e_addr[c]]));
      if (c_retry[c]) checkOutput({pre, " retry_cnt"}, 64'(retry_cnt_o), 64'(e_retry[c]));
    end
  endtask

  task automatic fillSgpr(input bit pattern);
    for (int i = 0; i <= NREG; i++)
      sgpr_mem[i] = pattern ? DW'(32'h1000 + i) : DW'($urandom);
  endtask

  initial begin
    int mode, nerr;
    rst_n      = 1'b0;
    error_i    = 1'b0;
    halt_ack_i = 1'b0;
    fillSgpr(1);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("reset fetch_block", 64'(fetch_block_o), 64'd0);
    checkOutput("reset rf_we", 64'(rf_we_o), 64'd0);
    checkOutput("reset done", 64'(done_o), 64'd0);
    checkOutput("reset fatal", 64'(fatal_o), 64'd0);
    checkOutput("reset retry_cnt", 64'(retry_cnt_o), 64'd0);
    checkOutput("reset rf_waddr", 64'(rf_waddr_o), 64'd1);
    checkOutput("reset sgpr_raddr", 64'(sgpr_raddr_o), 64'd1);

    // Clean recovery, ack already high: 31 writes, done at ack+32.
    applyStimulus(0, 0, 0);
    runEpisode();

    // Delayed ack: fetch held, no writes until the ack is seen.
    fillSgpr(0);
    applyStimulus(11, 0, 0);
    runEpisode();

    // Single error at x7: one restart, then a full copy.
    err_pos[0] = 7;
    applyStimulus(0, 1, 0);
    runEpisode();

    // Four errors exceed the budget of three: fatal, then reset.
    err_pos[0] = 5; err_pos[1] = 31; err_pos[2] = 1; err_pos[3] = 12;
    applyStimulus(3, 4, 0);
    runEpisode();

    // Reset while copying x15: partial copy abandoned.
    applyStimulus(2, 0, 15);
    runEpisode();

    // Randomised episodes.
    for (int e = 0; e < 25; e++) begin
      fillSgpr(0);
      mode = int'($urandom_range(0, 9));
      for (int k = 0; k < 4; k++) err_pos[k] = int'($urandom_range(1, NREG));
      if (mode == 0) begin
        applyStimulus(int'($urandom_range(0, 12)), 0, int'($urandom_range(1, NREG)));
      end else begin
        nerr = (mode <= 2) ? 4 : int'($urandom_range(0, MAXR));
        applyStimulus(int'($urandom_range(0, 12)), nerr, 0);
      end
      runEpisode();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
